// File: rtl/quad_paddle_tracker_if.sv
// Signal bundle between the quadrature paddle tracker and its surroundings:
// raw encoder pins, frame sync and error clear in; committed position and status out.
interface quad_paddle_tracker_if;
    logic       quad_a;
    logic       quad_b;
    logic       vga_v_sync;
    logic       clear_err;
    logic [9:0] player_pos;
    logic       frame_moved;
    logic       direction;
    logic       quad_err;

    modport master (
        output quad_a, quad_b, vga_v_sync, clear_err,
        input  player_pos, frame_moved, direction, quad_err
    );

    modport slave (
        input  quad_a, quad_b, vga_v_sync, clear_err,
        output player_pos, frame_moved, direction, quad_err
    );
endinterface

// File: rtl/quad_paddle_tracker.sv
// Quadrature paddle decoder: synchronizes encoder pins, decodes at 4x, clamps a working
// position and commits it to player_pos once per frame on the vsync rising edge.
//
// state    | meaning
// ST_PRIME | synchronizers filling; decode held off, prev-state loaded on the last cycle
// ST_RUN   | primed; every cycle compares synchronized {a,b} against prev-state
module quad_paddle_tracker #(
    parameter int POS_MIN     = 0,
    parameter int POS_MAX     = 575,
    parameter int POS_INIT    = 100,
    parameter int STEP        = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    quad_paddle_tracker_if.slave  bus
);

    localparam int CNT_W = $clog2(SYNC_STAGES + 1);
    localparam logic signed [11:0] MIN_S  = 12'(POS_MIN);
    localparam logic signed [11:0] MAX_S  = 12'(POS_MAX);
    localparam logic signed [11:0] STEP_S = 12'(STEP);

    typedef enum logic {ST_PRIME, ST_RUN} state_t;

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       prime_cnt, prime_cnt_nxt;
    logic                   load_prev, decode_en;

    logic [SYNC_STAGES-1:0] sync_a, sync_b;
    logic [1:0]             cur_ab, prev_ab;
    logic                   step_inc, step_dec, illegal;
    logic                   vsync_d, commit;

    logic [9:0]             working_pos, work_nxt;
    logic [9:0]             player_pos_q;
    logic                   frame_moved_q, direction_q, quad_err_q;
    logic signed [11:0]     wp_ext, pos_up, pos_dn;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], bus.quad_a};
            sync_b <= {sync_b[SYNC_STAGES-2:0], bus.quad_b};
        end
    end

    assign cur_ab = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_PRIME;
            prime_cnt <= CNT_W'(SYNC_STAGES);
        end else begin
            state     <= state_nxt;
            prime_cnt <= prime_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        prime_cnt_nxt = prime_cnt;
        load_prev     = 1'b0;
        decode_en     = 1'b0;
        case (state)
            ST_PRIME: begin
                if (prime_cnt == '0) begin
                    load_prev = 1'b1;
                    state_nxt = ST_RUN;
                end else begin
                    prime_cnt_nxt = prime_cnt - CNT_W'(1);
                end
            end
            ST_RUN:  decode_en = 1'b1;
            default: state_nxt = ST_PRIME;
        endcase
    end

    // Gray sequence 00->01->11->10->00 counts up; the reverse counts down.
    always_comb begin
        step_inc = 1'b0;
        step_dec = 1'b0;
        if (decode_en) begin
            case ({prev_ab, cur_ab})
                4'b0001, 4'b0111, 4'b1110, 4'b1000: step_inc = 1'b1;
                4'b0100, 4'b1101, 4'b1011, 4'b0010: step_dec = 1'b1;
                default: ;
            endcase
        end
    end

    assign illegal = decode_en && ((prev_ab ^ cur_ab) == 2'b11);
    assign commit  = bus.vga_v_sync && !vsync_d;

    // Widened to 12-bit signed so a step past either bound clamps instead of wrapping.
    always_comb begin
        wp_ext   = signed'({2'b00, working_pos});
        pos_up   = wp_ext + STEP_S;
        pos_dn   = wp_ext - STEP_S;
        work_nxt = working_pos;
        if (step_inc)
            work_nxt = (pos_up > MAX_S) ? MAX_S[9:0] : pos_up[9:0];
        else if (step_dec)
            work_nxt = (pos_dn < MIN_S) ? MIN_S[9:0] : pos_dn[9:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_ab       <= 2'b00;
            vsync_d       <= 1'b0;
            working_pos   <= 10'(POS_INIT);
            player_pos_q  <= 10'(POS_INIT);
            frame_moved_q <= 1'b0;
            direction_q   <= 1'b0;
            quad_err_q    <= 1'b0;
        end else begin
            if (load_prev || decode_en)
                prev_ab <= cur_ab;
            vsync_d     <= bus.vga_v_sync;
            working_pos <= work_nxt;
            if (commit)
                player_pos_q <= working_pos;
            frame_moved_q <= commit && (working_pos != player_pos_q);
            if (step_inc)
                direction_q <= 1'b1;
            else if (step_dec)
                direction_q <= 1'b0;
            if (illegal)
                quad_err_q <= 1'b1;
            else if (bus.clear_err)
                quad_err_q <= 1'b0;
        end
    end

    assign bus.player_pos  = player_pos_q;
    assign bus.frame_moved = frame_moved_q;
    assign bus.direction   = direction_q;
    assign bus.quad_err    = quad_err_q;

endmodule

// File: doc/quad_paddle_tracker.md
Name: quad_paddle_tracker

Overview:
Upstream feeder for the sprite/player position consumed by the pong top level (player_x). Synchronizes the raw quadrature encoder pins (quadA/quadB) and decodes them at 4x resolution. It accumulates a clamped working position and commits it to the player position output once per frame, on the rising edge of vga_v_sync, so the sprite never moves mid-frame.

Parameters:
POS_MIN, 0, lowest legal position (pixels)
POS_MAX, 575, highest legal position (pixels); POS_MIN < POS_MAX <= 1023
POS_INIT, 100, working and committed position after reset
STEP, 2, pixels moved per decoded quadrature count (1..15)
SYNC_STAGES, 2, flip-flop depth of input synchronizers (>=2)

Ports:
clk  input  1  pixel clock (PLL output, same domain as hvsync_generator)
reset_n  input  1  asynchronous, active-low reset
quad_a  input  1  raw encoder phase A, asynchronous
quad_b  input  1  raw encoder phase B, asynchronous
vga_v_sync  input  1  vertical sync from hvsync_generator; rising edge = frame commit
clear_err  input  1  synchronous clear of error flag
player_pos  output  10  committed position, stable for a whole frame
frame_moved  output  1  1-cycle pulse at a commit that changed player_pos
direction  output  1  sign of last decoded count (1 = increment)
quad_err  output  1  sticky: illegal quadrature transition seen

Behaviour:
- Reset (async assert, sync release on clk): synchronizer FFs = 0, prev-state = 0, vsync_d = 0, primed = 0, working_pos = POS_INIT, player_pos = POS_INIT, frame_moved = 0, direction = 0, quad_err = 0.
- Synchronizer: quad_a/quad_b each pass SYNC_STAGES FFs; decode uses the last stage only.
- Priming: a counter holds decode off for SYNC_STAGES+1 cycles after reset release. On its final cycle, prev-state loads the synchronized {a,b} with no count and no error. primed is then 1.
- Decode (each cycle, primed only), cur = {a,b}, prev = last sampled value:
  - Increment sequence is 00->01->11->10->00 (+1).
  - The reverse sequence is -1.
  - cur == prev: no action.
  - Both bits changed: illegal. quad_err <= 1; no count; prev still updates to cur.
  - direction updates only on a legal count.
- Working position arithmetic is done in 12-bit signed so nothing wraps:
  - +1: working_pos <= min(working_pos + STEP, POS_MAX).
  - -1: working_pos <= max(working_pos - STEP, POS_MIN).
  - At a bound, further counts in the same direction leave working_pos unchanged.
- Commit: vsync_d registers vga_v_sync. A commit happens in the cycle where vga_v_sync = 1 and vsync_d = 0.
  - player_pos <= the working_pos register value at the start of that cycle.
  - A count decoded in that same cycle updates working_pos as usual and is committed at the next frame.
- frame_moved = 1 for exactly the commit cycle +1 (registered) when the new player_pos differs from the old; 0 otherwise.
- Latency: the edge on the last sync stage to the working_pos update is 1 cycle. Pin to working_pos is SYNC_STAGES+1 cycles. Working to player_pos is at the next vsync rising edge.
- quad_err: set by an illegal transition, cleared by clear_err. If both occur in the same cycle, set wins.
- vga_v_sync held high: only one commit per rising edge. A glitch-free level is assumed from hvsync_generator; the block does not filter vsync.
- Reset mid-frame or mid-count: all state returns to reset values immediately. The partial count is discarded and priming reruns.

Test Plan:
- Reset release, inputs {a,b} = 11 held -> no quad_err; player_pos = 100; after one vsync rising edge, player_pos = 100 and frame_moved stays 0.
- 8 increment transitions (two full cycles 00->01->11->10->00), then a vsync edge -> player_pos = 116, frame_moved pulses 1 cycle, direction = 1.
- From 100, 60 decrement transitions then vsync -> player_pos = 0 (clamped at POS_MIN, no wrap to 1023); then 2 increments + vsync -> 4.
- Drive toward POS_MAX: 300 increments from 100, vsync -> player_pos = 575; extra increments + vsync -> 575, frame_moved = 0.
- Jump 00->11 -> quad_err = 1 and position unchanged. Then clear_err asserted in the same cycle as another illegal 01->10 -> quad_err stays 1; clear_err alone next cycle -> 0.
- Increment on the exact commit cycle, working 110 -> 112 -> player_pos = 110 this frame, 112 after the next vsync edge. Then assert reset_n low mid-count -> player_pos = 100 with no clock edge required.
